johnson_phase_decoder: RTL and testbench

Downstream consumer of the 4-bit twisted-ring (Johnson) counter. Samples the counter's code each enabled cycle, decodes it to a phase index and a one-hot phase vector, and checks code legality and step-by-step sequence. Counts completed rotations and flags illegal or skipped codes. Feeds phase-sequenced enables to the control logic downstream.

---
 rtl/johnson_phase_decoder.sv | 170 +++++++++++++++++
 tb/tb_johnson_phase_decoder.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/johnson_phase_decoder.sv
// Johnson counter phase decoder: decodes the upstream twisted-ring code into
// a phase index and one-hot vector, tracks sequence lock and counts rotations.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   in_valid, jc_in       jc_in is sampled only when in_valid=1
//   clr_err               clears err_sticky (a new error in the same cycle wins)
//   phase_idx             decoded phase 0..2N-1 (held while not LOCKED)
//   phase_onehot          bit phase_idx set while phase_valid, else zero
//   phase_valid, locked   FSM is in LOCKED
//   wrap_pulse            one-cycle pulse on the 2N-1 -> 0 step
//   cycle_count           completed rotations, modulo 2^CW
//   seq_err_pulse         one-cycle pulse: legal code out of sequence
//   illegal_pulse         one-cycle pulse: non-Johnson code
//   err_sticky            set by any error pulse, held until clr_err
module johnson_phase_decoder #(
    parameter int N  = 4,
    parameter int CW = 8,
    localparam int IW = $clog2(2 * N)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [N-1:0]    jc_in,
    input  logic            clr_err,
    output logic [IW-1:0]   phase_idx,
    output logic [2*N-1:0]  phase_onehot,
    output logic            phase_valid,
    output logic            locked,
    output logic            wrap_pulse,
    output logic [CW-1:0]   cycle_count,
    output logic            seq_err_pulse,
    output logic            illegal_pulse,
    output logic            err_sticky
);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        LOCKED = 2'd1,
        ERROR  = 2'd2
    } state_t;

    state_t state, state_n;

    logic [IW-1:0]  idx_n;
    logic [2*N-1:0] onehot_n;
    logic [CW-1:0]  cnt_n;
    logic           wrap_n;
    logic           seq_n;
    logic           ill_n;
    logic           sticky_n;

    int             ones;
    int             cidx;
    logic [N-1:0]   regen;
    logic           legal;
    logic [IW-1:0]  code_idx;
    logic [IW-1:0]  nxt_idx;

    // Code -> index: the count of ones gives the index on the rising half,
    // the mirrored count on the falling half (MSB set). The code is legal
    // only if regenerating it from that index reproduces the input exactly.
    always_comb begin
        ones = $countones(jc_in);
        cidx = jc_in[N-1] ? (2 * N - ones) : ones;
        for (int b = 0; b < N; b++) begin
            if (cidx <= N) begin
                regen[b] = (b < cidx);
            end else begin
                regen[b] = (b >= cidx - N);
            end
        end
        legal    = (regen == jc_in);
        code_idx = cidx[IW-1:0];
        nxt_idx  = (phase_idx == IW'(2 * N - 1)) ? '0 : phase_idx + IW'(1);
    end

    always_comb begin
        state_n = state;
        idx_n   = phase_idx;
        cnt_n   = cycle_count;
        wrap_n  = 1'b0;
        seq_n   = 1'b0;
        ill_n   = 1'b0;
        if (in_valid) begin
            unique case (state)
                SYNC: begin
                    if (!legal) begin
                        ill_n = 1'b1;
                    end else if (code_idx == '0) begin
                        state_n = LOCKED;
                        idx_n   = '0;
                    end
                end
                LOCKED: begin
                    if (!legal) begin
                        ill_n   = 1'b1;
                        state_n = ERROR;
                    end else if (code_idx == nxt_idx) begin
                        idx_n = nxt_idx;
                        if (nxt_idx == '0) begin
                            wrap_n = 1'b1;
                            cnt_n  = cycle_count + CW'(1);
                        end
                    end else if (code_idx == phase_idx) begin
                        // upstream stall: hold
                        idx_n = phase_idx;
                    end else if (code_idx == '0) begin
                        // unexpected zero: upstream was reset
                        idx_n = '0;
                    end else begin
                        seq_n   = 1'b1;
                        state_n = ERROR;
                    end
                end
                ERROR: begin
                    if (!legal) begin
                        ill_n = 1'b1;
                    end else if (code_idx == '0) begin
                        state_n = LOCKED;
                        idx_n   = '0;
                    end
                end
                default: begin
                    state_n = SYNC;
                end
            endcase
        end

        if (seq_n || ill_n) begin
            sticky_n = 1'b1;
        end else if (clr_err) begin
            sticky_n = 1'b0;
        end else begin
            sticky_n = err_sticky;
        end

        onehot_n = '0;
        if (state_n == LOCKED) begin
            onehot_n[idx_n] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= SYNC;
            phase_idx     <= '0;
            phase_onehot  <= '0;
            locked        <= 1'b0;
            wrap_pulse    <= 1'b0;
            cycle_count   <= '0;
            seq_err_pulse <= 1'b0;
            illegal_pulse <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            state         <= state_n;
            phase_idx     <= idx_n;
            phase_onehot  <= onehot_n;
            locked        <= (state_n == LOCKED);
            wrap_pulse    <= wrap_n;
            cycle_count   <= cnt_n;
            seq_err_pulse <= seq_n;
            illegal_pulse <= ill_n;
            err_sticky    <= sticky_n;
        end
    end

    assign phase_valid = locked;

endmodule

// File: tb/tb_johnson_phase_decoder.sv
// Directed bench for johnson_phase_decoder (N=4, CW=8).
// One task per scenario, each with its own inline comparisons.
module tb_johnson_phase_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] jc_in;
    logic       clr_err;
    logic [2:0] phase_idx;
    logic [7:0] phase_onehot;
    logic       phase_valid;
    logic       locked;
    logic       wrap_pulse;
    logic [7:0] cycle_count;
    logic       seq_err_pulse;
    logic       illegal_pulse;
    logic       err_sticky;

    int checks = 0;
    int errors = 0;

    logic [3:0] seq [8] = '{4'b0000, 4'b0001, 4'b0011, 4'b0111,
                            4'b1111, 4'b1110, 4'b1100, 4'b1000};

    johnson_phase_decoder #(.N(4), .CW(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .jc_in         (jc_in),
        .clr_err       (clr_err),
        .phase_idx     (phase_idx),
        .phase_onehot  (phase_onehot),
        .phase_valid   (phase_valid),
        .locked        (locked),
        .wrap_pulse    (wrap_pulse),
        .cycle_count   (cycle_count),
        .seq_err_pulse (seq_err_pulse),
        .illegal_pulse (illegal_pulse),
        .err_sticky    (err_sticky)
    );

    always #5 clk = ~clk;

    // Drive on the falling edge, return 1 time unit after the next rising edge.
    task automatic drive(input logic v, input logic [3:0] c);
        @(negedge clk);
        in_valid = v;
        jc_in    = c;
        @(posedge clk);
        #1;
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b1, 4'b0000);
        drive(1'b1, 4'b0000);
        checks++;
        if ({phase_idx, phase_onehot, phase_valid, locked, wrap_pulse,
             cycle_count, seq_err_pulse, illegal_pulse, err_sticky} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: idx=%0d oh=%h lk=%b cnt=%0d err=%b",
                     phase_idx, phase_onehot, locked, cycle_count, err_sticky);
        end
        reset = 1'b0;
    endtask

    task automatic test_sequence;
        int wraps = 0;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, seq[i % 8]);
            wraps += int'(wrap_pulse);
            checks++;
            if (phase_idx !== 3'(i % 8) || phase_onehot !== 8'(1 << (i % 8))
                || locked !== 1'b1 || phase_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_step%0d: idx=%0d oh=%h lk=%b pv=%b exp idx=%0d",
                         i, phase_idx, phase_onehot, locked, phase_valid, i % 8);
            end
        end
        checks++;
        if (wraps != 1 || cycle_count !== 8'd1) begin
            errors++;
            $display("FAIL seq_wrap: wraps=%0d cnt=%0d exp 1/1", wraps, cycle_count);
        end
    endtask

    task automatic test_rollover;
        int bad = 0;
        for (int r = 0; r < 255; r++) begin
            for (int i = 1; i <= 8; i++) begin
                if (r == 254 && i == 8) begin
                    checks++;
                    if (cycle_count !== 8'd255) begin
                        errors++;
                        $display("FAIL roll_255: cnt=%0d exp 255", cycle_count);
                    end
                end
                drive(1'b1, seq[i % 8]);
                if (seq_err_pulse || illegal_pulse || !locked) bad++;
            end
        end
        checks++;
        if (cycle_count !== 8'd0 || wrap_pulse !== 1'b1 || bad != 0
            || err_sticky !== 1'b0) begin
            errors++;
            $display("FAIL roll_zero: cnt=%0d wrap=%b bad=%0d sticky=%b exp 0/1/0/0",
                     cycle_count, wrap_pulse, bad, err_sticky);
        end
    endtask

    task automatic test_illegal;
        for (int i = 1; i <= 3; i++) drive(1'b1, seq[i]);
        drive(1'b1, 4'b0101);
        checks++;
        if (illegal_pulse !== 1'b1 || err_sticky !== 1'b1 || locked !== 1'b0
            || phase_onehot !== 8'h00 || phase_idx !== 3'd3 || seq_err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL ill_detect: ill=%b st=%b lk=%b oh=%h idx=%0d",
                     illegal_pulse, err_sticky, locked, phase_onehot, phase_idx);
        end
        drive(1'b1, 4'b0011);
        checks++;
        if (illegal_pulse !== 1'b0 || seq_err_pulse !== 1'b0 || locked !== 1'b0) begin
            errors++;
            $display("FAIL err_legal: ill=%b seq=%b lk=%b exp 0/0/0",
                     illegal_pulse, seq_err_pulse, locked);
        end
        drive(1'b1, 4'b1011);
        checks++;
        if (illegal_pulse !== 1'b1 || locked !== 1'b0) begin
            errors++;
            $display("FAIL err_illegal: ill=%b lk=%b exp 1/0", illegal_pulse, locked);
        end
        drive(1'b1, 4'b0000);
        checks++;
        if (locked !== 1'b1 || phase_idx !== 3'd0 || illegal_pulse !== 1'b0
            || err_sticky !== 1'b1 || wrap_pulse !== 1'b0 || cycle_count !== 8'd0) begin
            errors++;
            $display("FAIL ill_relock: lk=%b idx=%0d ill=%b st=%b wrap=%b cnt=%0d",
                     locked, phase_idx, illegal_pulse, err_sticky, wrap_pulse, cycle_count);
        end
        clr_err = 1'b1;
        drive(1'b0, 4'b0000);
        checks++;
        if (err_sticky !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL ill_clear: st=%b lk=%b exp 0/1", err_sticky, locked);
        end
    endtask

    task automatic test_skip;
        drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0011);
        clr_err = 1'b1;
        drive(1'b1, 4'b1111);
        checks++;
        if (seq_err_pulse !== 1'b1 || err_sticky !== 1'b1 || locked !== 1'b0
            || illegal_pulse !== 1'b0) begin
            errors++;
            $display("FAIL skip_err: seq=%b st=%b lk=%b ill=%b exp 1/1/0/0",
                     seq_err_pulse, err_sticky, locked, illegal_pulse);
        end
        clr_err = 1'b1;
        drive(1'b1, 4'b0000);
        checks++;
        if (seq_err_pulse !== 1'b0 || err_sticky !== 1'b0 || locked !== 1'b1
            || phase_idx !== 3'd0) begin
            errors++;
            $display("FAIL skip_recover: seq=%b st=%b lk=%b idx=%0d",
                     seq_err_pulse, err_sticky, locked, phase_idx);
        end
    endtask

    task automatic test_stall;
        for (int i = 1; i <= 5; i++) drive(1'b1, seq[i]);
        for (int i = 0; i < 3; i++) drive(1'b0, 4'b0101);
        checks++;
        if (phase_idx !== 3'd5 || illegal_pulse !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL stall_invalid: idx=%0d ill=%b lk=%b exp 5/0/1",
                     phase_idx, illegal_pulse, locked);
        end
        drive(1'b1, 4'b1110);
        drive(1'b1, 4'b1110);
        checks++;
        if (phase_idx !== 3'd5 || phase_onehot !== 8'h20 || seq_err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL stall_repeat: idx=%0d oh=%h seq=%b exp 5/20/0",
                     phase_idx, phase_onehot, seq_err_pulse);
        end
        drive(1'b1, 4'b1100);
        checks++;
        if (phase_idx !== 3'd6 || err_sticky !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL stall_adv: idx=%0d st=%b lk=%b exp 6/0/1",
                     phase_idx, err_sticky, locked);
        end
        drive(1'b1, 4'b0000);
        checks++;
        if (phase_idx !== 3'd0 || wrap_pulse !== 1'b0 || cycle_count !== 8'd0
            || err_sticky !== 1'b0 || locked !== 1'b1) begin
            errors++;
            $display("FAIL upstream_rst: idx=%0d wrap=%b cnt=%0d st=%b lk=%b",
                     phase_idx, wrap_pulse, cycle_count, err_sticky, locked);
        end
    endtask

    task automatic test_reset_midrun;
        for (int r = 0; r < 3; r++) begin
            for (int i = 1; i <= 8; i++) drive(1'b1, seq[i % 8]);
        end
        for (int i = 1; i <= 6; i++) drive(1'b1, seq[i]);
        checks++;
        if (phase_idx !== 3'd6 || cycle_count !== 8'd3) begin
            errors++;
            $display("FAIL pre_reset: idx=%0d cnt=%0d exp 6/3", phase_idx, cycle_count);
        end
        reset = 1'b1;
        drive(1'b1, 4'b1000);
        reset = 1'b0;
        checks++;
        if ({phase_idx, phase_onehot, phase_valid, locked, wrap_pulse,
             cycle_count, seq_err_pulse, illegal_pulse, err_sticky} !== '0) begin
            errors++;
            $display("FAIL midrun_reset: idx=%0d oh=%h lk=%b cnt=%0d wrap=%b",
                     phase_idx, phase_onehot, locked, cycle_count, wrap_pulse);
        end
        drive(1'b1, 4'b0011);
        checks++;
        if (locked !== 1'b0 || illegal_pulse !== 1'b0 || seq_err_pulse !== 1'b0) begin
            errors++;
            $display("FAIL sync_hold: lk=%b ill=%b seq=%b exp 0/0/0",
                     locked, illegal_pulse, seq_err_pulse);
        end
        drive(1'b1, 4'b0000);
        checks++;
        if (locked !== 1'b1 || phase_idx !== 3'd0 || phase_onehot !== 8'h01) begin
            errors++;
            $display("FAIL sync_lock: lk=%b idx=%0d oh=%h exp 1/0/01",
                     locked, phase_idx, phase_onehot);
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        jc_in    = 4'b0000;
        clr_err  = 1'b0;
        test_reset();
        test_sequence();
        test_rollover();
        test_illegal();
        test_skip();
        test_stall();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
